// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a registered carry produces one
// sum bit per clock; {cout, sum} is registered and announced by a done pulse.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] part_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] part_next;
    logic             s_bit;
    logic             carry_next;
    logic             last_bit;

    // The single full-adder cell, always looking at the operand LSBs.
    assign s_bit      = a_reg[0] ^ b_reg[0] ^ carry_reg;
    assign carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);
    assign last_bit   = (cnt_reg == LAST_BIT);

    // Operands shift toward the LSB; each new sum bit enters the partial MSB.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_top
                assign a_next[gi]    = 1'b0;
                assign b_next[gi]    = 1'b0;
                assign part_next[gi] = s_bit;
            end else begin : g_low
                assign a_next[gi]    = a_reg[gi+1];
                assign b_next[gi]    = b_reg[gi+1];
                assign part_next[gi] = part_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            part_reg  <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        carry_reg <= c_in;
                        part_reg  <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_reg     <= a_next;
                    b_reg     <= b_next;
                    part_reg  <= part_next;
                    carry_reg <= carry_next;
                    if (last_bit) begin
                        // Publish from the next-values so the final bit lands on this edge.
                        sum_reg   <= part_next;
                        cout_reg  <= carry_next;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder against an arithmetic model
// of {cout, sum} = a + b + c with the documented cycle timing.
module tb_serial_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         c_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [W:0] model_res = '0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int total;
        total = int'(a) + int'(b) + int'(c);
        return (W+1)'(total % (1 << (W + 1)));
    endfunction

    // mode 0: plain op; 1: extra start pulses while busy; 2: reset at edge k+2
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input int mode);
        logic [W:0] expv;
        expv = ref_add(a, b, c);
        a_in = a; b_in = b; c_in = c; start = 1'b1;
        tick();
        start = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom);
        for (int j = 0; j <= W + 1; j++) begin
            if (mode == 2 && j >= 2) begin
                model_res = '0;
                chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
                chk({tag, "_rst_done"}, 32'(done), 32'd0);
                chk({tag, "_rst_res"}, 32'({cout, sum}), 32'd0);
            end else if (j < W) begin
                chk({tag, "_busy"}, 32'(busy), 32'd1);
                chk({tag, "_nodone"}, 32'(done), 32'd0);
                chk({tag, "_held"}, 32'({cout, sum}), 32'(model_res));
            end else if (j == W) begin
                chk({tag, "_done"}, 32'(done), 32'd1);
                chk({tag, "_idlebusy"}, 32'(busy), 32'd0);
                chk({tag, "_res"}, 32'({cout, sum}), 32'(expv));
                model_res = expv;
            end else begin
                chk({tag, "_donepulse"}, 32'(done), 32'd0);
                chk({tag, "_after"}, 32'({cout, sum}), 32'(model_res));
            end
            if (mode == 1) begin
                start = (j == 1 || j == 3);
                a_in = W'(7); b_in = W'(7); c_in = 1'b0;
            end
            if (mode == 2) rst = (j == 1);
            tick();
        end
        start = 1'b0;
        rst = 1'b0;
        if (mode == 1) begin
            for (int j = 0; j < 4; j++) begin
                chk({tag, "_no2nd_done"}, 32'(done), 32'd0);
                chk({tag, "_no2nd_busy"}, 32'(busy), 32'd0);
                tick();
            end
        end
    endtask

    initial begin
        int n;
        int last_done;
        logic [W:0] expv;

        // Reset then idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_res = '0;
        for (int i = 0; i < 5; i++) begin
            chk("reset_busy", 32'(busy), 32'd0);
            chk("reset_done", 32'(done), 32'd0);
            chk("reset_res", 32'({cout, sum}), 32'd0);
            tick();
        end

        do_op("basic_3p5", W'(3), W'(5), 1'b0, 0);
        do_op("chain_15p15p1", W'(15), W'(15), 1'b1, 0);
        do_op("zero", W'(0), W'(0), 1'b0, 0);
        do_op("start_busy", W'(1), W'(1), 1'b0, 1);
        do_op("rst_mid", W'(9), W'(9), 1'b1, 2);
        do_op("after_rst", W'(9), W'(9), 1'b1, 0);

        for (int i = 0; i < 30; i++) begin
            do_op("rand", W'($urandom), W'($urandom), 1'($urandom), 0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end

        // Exhaustive with start held high: one result every W+2 cycles
        last_done = 0;
        for (int i = 0; i < 512; i++) begin
            a_in = W'((i >> 5) & 15);
            b_in = W'((i >> 1) & 15);
            c_in = 1'(i & 1);
            expv = ref_add(a_in, b_in, c_in);
            start = 1'b1;
            n = 0;
            do begin
                tick();
                n++;
            end while (!done && n < 20);
            chk("exh_timeout", 32'(done), 32'd1);
            chk("exh_res", 32'({cout, sum}), 32'(expv));
            if (i > 0) chk("exh_gap", 32'(cyc - last_done), 32'(W + 2));
            last_done = cyc;
        end
        start = 1'b0;
        tick();
        tick();
        chk("exh_end_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
